// File: rtl/pulse_meter.sv
// pulse_meter -- measures high width and rise-to-rise period of one selected
// channel of an 8-bit pulse bus, in clk cycles.
//
// Ports:
//   clk       system clock
//   reset     asynchronous reset, active low
//   pulse_in  8 pulse channels, may be asynchronous to clk
//   ch_sel    channel to measure, captured when a start is accepted
//   start     measurement request, level-sampled, accepted only when idle
//   busy      high from the cycle after an accepted start through the done cycle
//   done      one-cycle strobe, results valid
//   timeout   measurement aborted on counter saturation; held until next start
//   high_w    measured high time (cycles)
//   period    measured rise-to-rise time (cycles)

// Two-flop synchronizer for one pulse channel.
module pulse_meter_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;
endmodule

module pulse_meter #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       pulse_in,
  input  logic [2:0]       ch_sel,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] high_w,
  output logic [CNT_W-1:0] period
);
  localparam int NUM_CH = 8;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_HIGH,
    S_LOW,
    S_DONE
  } state_t;

  // Every channel is synchronized so the mux after the flops never switches
  // between a settled and a metastable source.
  logic [NUM_CH-1:0] pulse_s;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_sync
    pulse_meter_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (pulse_in[gi]),
      .q     (pulse_s[gi])
    );
  end

  state_t           state_q, state_d;
  logic [2:0]       ch_q, ch_d;
  logic             s_d_q, s_d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] high_w_q, high_w_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             timeout_q, timeout_d;

  logic s;
  logic rise;
  logic fall;
  logic sat;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    s       = pulse_s[ch_q];
    rise    = s & ~s_d_q;
    fall    = ~s & s_d_q;
    sat     = &cnt_q;
    // Hold at all-ones once saturated so the counter never wraps to 0.
    cnt_inc = sat ? cnt_q : cnt_q + CNT_ONE;
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    s_d_d     = s;
    cnt_d     = cnt_q;
    high_w_d  = high_w_q;
    period_d  = period_q;
    timeout_d = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ch_d      = ch_sel;
          cnt_d     = '0;
          timeout_d = 1'b0;
          high_w_d  = '0;
          period_d  = '0;
          // Seed the edge detector with the newly selected channel so a
          // level already high at start, or a channel switch, is not a rise.
          s_d_d     = pulse_s[ch_sel];
          state_d   = S_ARM;
        end
      end

      S_ARM: begin
        cnt_d = cnt_inc;
        if (sat) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else if (rise) begin
          cnt_d   = CNT_ONE;
          state_d = S_HIGH;
        end
      end

      S_HIGH: begin
        cnt_d = cnt_inc;
        if (sat) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else if (fall) begin
          high_w_d = cnt_q;
          state_d  = S_LOW;
        end
      end

      S_LOW: begin
        cnt_d = cnt_inc;
        if (sat) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else if (rise) begin
          period_d = cnt_q;
          cnt_d    = CNT_ONE;
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ch_q      <= 3'd0;
      s_d_q     <= 1'b0;
      cnt_q     <= '0;
      high_w_q  <= '0;
      period_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      s_d_q     <= s_d_d;
      cnt_q     <= cnt_d;
      high_w_q  <= high_w_d;
      period_q  <= period_d;
      timeout_q <= timeout_d;
    end
  end

  // Status decodes straight from the state register, so an async reset
  // clears them in the same instant as the state.
  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    timeout = timeout_q;
    high_w  = high_w_q;
    period  = period_q;
  end
endmodule

// File: tb/tb_pulse_meter.sv
// Bench for pulse_meter: a 24-bit instance for the measurement cases and an
// 8-bit instance for the saturation cases, sharing one pulse bus.
module tb_pulse_meter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #10 clk = ~clk;

  logic [7:0] pulse_in = 8'h00;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [2:0] ch_a = 3'd0, ch_b = 3'd0;
  logic       busy_a, done_a, to_a, busy_b, done_b, to_b;
  logic [23:0] hw_a, per_a;
  logic [7:0]  hw_b, per_b;

  pulse_meter #(.CNT_W(24)) dut_a (
    .clk(clk), .reset(reset), .pulse_in(pulse_in), .ch_sel(ch_a), .start(start_a),
    .busy(busy_a), .done(done_a), .timeout(to_a), .high_w(hw_a), .period(per_a)
  );

  pulse_meter #(.CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .pulse_in(pulse_in), .ch_sel(ch_b), .start(start_b),
    .busy(busy_b), .done(done_b), .timeout(to_b), .high_w(hw_b), .period(per_b)
  );

  typedef struct packed {
    logic [23:0] hw;
    logic [23:0] per;
    logic        to;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int dones_a = 0;
  int dones_b = 0;

  // Channel waveform table: period / high cycles.
  int per_cfg[8] = '{100, 30, 12, 50, 64, 20, 40, 10};
  int hi_cfg[8]  = '{ 50, 12,  3, 10, 60,  7,  2,  0};
  logic [7:0] ovr_en  = 8'h80;
  logic [7:0] ovr_val = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pulse generator, updated on the falling edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 8; i++)
      pulse_in[i] = ovr_en[i] ? ovr_val[i] : ((cyc % per_cfg[i]) < hi_cfg[i]);
  end

  logic prev_done_a = 1'b0, prev_done_b = 1'b0;

  always @(negedge clk) begin
    if (prev_done_a) check("a_busy_fall", busy_a, 0);
    if (done_a) begin
      dones_a++;
      check("a_busy_at_done", busy_a, 1);
      if (q_a.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL a_done_unexpected: got done (high_w %0d period %0d), expected none", hw_a, per_a);
      end else begin
        e_a = q_a.pop_front();
        check("a_high_w", hw_a, e_a.hw);
        check("a_period", per_a, e_a.per);
        check("a_timeout", to_a, e_a.to);
      end
    end
    prev_done_a = done_a;
  end

  always @(negedge clk) begin
    if (prev_done_b) check("b_busy_fall", busy_b, 0);
    if (done_b) begin
      dones_b++;
      check("b_busy_at_done", busy_b, 1);
      if (q_b.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL b_done_unexpected: got done (high_w %0d period %0d), expected none", hw_b, per_b);
      end else begin
        e_b = q_b.pop_front();
        check("b_high_w", hw_b, e_b.hw);
        check("b_period", per_b, e_b.per);
        check("b_timeout", to_b, e_b.to);
      end
    end
    prev_done_b = done_b;
  end

  task automatic wait_idle(input bit sel, input string name, input int budget);
    int k = 0;
    while ((sel ? busy_b : busy_a) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (sel ? busy_b : busy_a) begin
      n_tests++; n_fail++;
      $display("FAIL %s_wait: busy still high after %0d cycles, expected low", name, budget);
    end
  endtask

  task automatic measure(input bit sel, input logic [2:0] ch, input logic [23:0] hw,
                         input logic [23:0] per, input logic to, input string name);
    exp_t e;
    e.hw = hw; e.per = per; e.to = to;
    @(negedge clk);
    if (sel) begin ch_b = ch; start_b = 1'b1; q_b.push_back(e); end
    else     begin ch_a = ch; start_a = 1'b1; q_a.push_back(e); end
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    check({name, "_busy_rise"}, sel ? busy_b : busy_a, 1);
    wait_idle(sel, name, 1000);
  endtask

  initial begin
    int d0;
    int t[3];
    int n;
    bit saw_busy;
    exp_t e;

    // Reset state
    repeat (10) @(negedge clk);
    check("rst_a_busy", busy_a, 0);
    check("rst_a_done", done_a, 0);
    check("rst_a_timeout", to_a, 0);
    check("rst_a_high_w", hw_a, 0);
    check("rst_a_period", per_a, 0);
    check("rst_b_busy", busy_b, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Basic measurement
    d0 = dones_a;
    measure(0, 3'd3, 24'd10, 24'd50, 1'b0, "basic");
    check("basic_one_done", dones_a - d0, 1);

    // Channel isolation
    measure(0, 3'd5, 24'd7, 24'd20, 1'b0, "ch5");
    measure(0, 3'd0, 24'd50, 24'd100, 1'b0, "ch0");

    // ch_sel change after acceptance has no effect
    e.hw = 24'd50; e.per = 24'd100; e.to = 1'b0;
    @(negedge clk); ch_a = 3'd0; start_a = 1'b1; q_a.push_back(e);
    @(negedge clk); start_a = 1'b0;
    repeat (30) @(negedge clk);
    ch_a = 3'd5;
    wait_idle(0, "chsel_change", 1000);

    // Remaining channels of the generator pattern
    measure(0, 3'd1, 24'd12, 24'd30, 1'b0, "ch1");
    measure(0, 3'd2, 24'd3,  24'd12, 1'b0, "ch2");
    measure(0, 3'd4, 24'd60, 24'd64, 1'b0, "ch4");
    measure(0, 3'd6, 24'd2,  24'd40, 1'b0, "ch6");

    // Start pulses while busy are ignored
    d0 = dones_a;
    e.hw = 24'd10; e.per = 24'd50; e.to = 1'b0;
    @(negedge clk); ch_a = 3'd3; start_a = 1'b1; q_a.push_back(e);
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (!busy_a) break;
      start_a = (!done_a && (k % 3 == 0));
    end
    start_a = 1'b0;
    saw_busy = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (busy_a) saw_busy = 1'b1;
    end
    check("busy_start_ignored", saw_busy, 0);
    check("busy_start_one_done", dones_a - d0, 1);

    // Start held: back-to-back measurements
    for (int k = 0; k < 3; k++) q_a.push_back(e);
    n = 0;
    @(negedge clk); ch_a = 3'd3; start_a = 1'b1;
    for (int k = 0; k < 1000 && n < 3; k++) begin
      @(negedge clk);
      if (done_a) begin
        t[n] = cyc;
        n++;
      end
    end
    start_a = 1'b0;
    check("b2b_count", n, 3);
    check("b2b_gap0", t[1] - t[0], 100);
    check("b2b_gap1", t[2] - t[1], 100);
    wait_idle(0, "b2b", 1000);

    // Narrow counter: normal result, then saturation with input low
    measure(1, 3'd5, 24'd7, 24'd20, 1'b0, "b_ch5");
    measure(1, 3'd7, 24'd0, 24'd0, 1'b1, "b_timeout_low");
    check("b_timeout_held", to_b, 1);

    // High at start is not a rise; saturation follows a fresh rise
    ovr_val[7] = 1'b1;
    repeat (5) @(negedge clk);
    d0 = dones_b;
    e.hw = 24'd0; e.per = 24'd0; e.to = 1'b1;
    @(negedge clk); ch_b = 3'd7; start_b = 1'b1; q_b.push_back(e);
    @(negedge clk); start_b = 1'b0;
    repeat (100) @(negedge clk);
    ovr_val[7] = 1'b0;
    repeat (5) @(negedge clk);
    ovr_val[7] = 1'b1;
    repeat (190) @(negedge clk);
    check("fresh_rise_no_early_done", dones_b - d0, 0);
    check("fresh_rise_still_busy", busy_b, 1);
    wait_idle(1, "fresh_rise", 1000);
    check("fresh_rise_done", dones_b - d0, 1);

    // Reset in the middle of a HIGH phase
    d0 = dones_a;
    @(negedge clk); ch_a = 3'd0; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    for (int k = 0; k < 300 && pulse_in[0]; k++) @(negedge clk);
    for (int k = 0; k < 300 && !pulse_in[0]; k++) @(negedge clk);
    repeat (10) @(negedge clk);
    check("mid_busy_before", busy_a, 1);
    #3 reset = 1'b0;
    #1;
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_done", done_a, 0);
    check("mid_rst_timeout", to_a, 0);
    check("mid_rst_high_w", hw_a, 0);
    check("mid_rst_period", per_a, 0);
    check("mid_rst_b_timeout", to_b, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (300) @(negedge clk);
    check("mid_rst_no_done", dones_a - d0, 0);
    check("mid_rst_idle", busy_a, 0);
    measure(0, 3'd3, 24'd10, 24'd50, 1'b0, "after_rst");

    repeat (5) @(negedge clk);
    check("q_a_empty", q_a.size(), 0);
    check("q_b_empty", q_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
